// File: rtl/subservient_sram_arb.sv
// Byte-serial arbiter sharing one 8-bit SRAM between a register-file port and two Wishbone masters.
// Define SUBSERVIENT_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority with m0 first.
module subservient_sram_arb #(
  parameter int unsigned depth = 256,
  parameter int unsigned aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [aw-1:0] i_rf_waddr,
  input  logic [7:0]    i_rf_wdata,
  input  logic          i_rf_wen,
  input  logic [aw-1:0] i_rf_raddr,
  input  logic          i_rf_ren,
  output logic [7:0]    o_rf_rdata,
  input  logic [aw-3:0] i_wb_m0_adr,
  input  logic [31:0]   i_wb_m0_dat,
  input  logic [3:0]    i_wb_m0_sel,
  input  logic          i_wb_m0_we,
  input  logic          i_wb_m0_stb,
  output logic [31:0]   o_wb_m0_rdt,
  output logic          o_wb_m0_ack,
  input  logic [aw-3:0] i_wb_m1_adr,
  input  logic [31:0]   i_wb_m1_dat,
  input  logic [3:0]    i_wb_m1_sel,
  input  logic          i_wb_m1_we,
  input  logic          i_wb_m1_stb,
  output logic [31:0]   o_wb_m1_rdt,
  output logic          o_wb_m1_ack,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  input  logic [7:0]    i_sram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ACK} state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic [1:0]    bsel_q, bsel_d;
  logic [23:0]   rdt_q;
  logic          rd_pend_q;
  logic [1:0]    rd_idx_q;
  logic          rf_act;
  logic          issue;
  logic          any_stb;
  logic          pick;
  logic [aw-3:0] cur_adr;
  logic [31:0]   cur_dat;
  logic [3:0]    cur_sel;
  logic          cur_we;

`ifdef SUBSERVIENT_ARB_ROUND_ROBIN_EN
  logic          last_q;
`endif

  assign rf_act  = i_rf_wen | i_rf_ren;
  assign any_stb = i_wb_m0_stb | i_wb_m1_stb;
  assign issue   = (state_q == S_XFER) && !rf_act;

  // Master selected for the request seen in IDLE (1 = m1)
`ifdef SUBSERVIENT_ARB_ROUND_ROBIN_EN
  assign pick = (i_wb_m0_stb && i_wb_m1_stb) ? ~last_q : i_wb_m1_stb;
`else
  assign pick = ~i_wb_m0_stb;
`endif

  assign cur_adr = grant_q ? i_wb_m1_adr : i_wb_m0_adr;
  assign cur_dat = grant_q ? i_wb_m1_dat : i_wb_m0_dat;
  assign cur_sel = grant_q ? i_wb_m1_sel : i_wb_m0_sel;
  assign cur_we  = grant_q ? i_wb_m1_we  : i_wb_m0_we;

  assign o_rf_rdata  = i_sram_rdata;
  // Byte 3 arrives during ACK and is forwarded straight from the SRAM
  assign o_wb_m0_rdt = {i_sram_rdata, rdt_q};
  assign o_wb_m1_rdt = {i_sram_rdata, rdt_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, SRAM port mux and acks; RF owns the SRAM whenever WB is not issuing
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    bsel_d       = bsel_q;
    o_sram_waddr = i_rf_waddr;
    o_sram_wdata = i_rf_wdata;
    o_sram_wen   = i_rf_wen;
    o_sram_raddr = i_rf_raddr;
    o_wb_m0_ack  = 1'b0;
    o_wb_m1_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_stb) begin
          state_d = S_XFER;
          grant_d = pick;
          bsel_d  = 2'd0;
        end
      end
      S_XFER: begin
        if (!rf_act) begin
          o_sram_waddr = {cur_adr, bsel_q};
          o_sram_raddr = {cur_adr, bsel_q};
          o_sram_wdata = 8'(cur_dat >> {bsel_q, 3'b000});
          o_sram_wen   = cur_we & cur_sel[bsel_q];
          bsel_d       = bsel_q + 2'd1;
          if (bsel_q == 2'd3) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        o_wb_m0_ack = ~grant_q;
        o_wb_m1_ack = grant_q;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Transfer bookkeeping and read-data assembly one cycle behind each issued byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_q   <= 1'b0;
      bsel_q    <= 2'd0;
      rdt_q     <= 24'd0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= 2'd0;
    end else begin
      grant_q   <= grant_d;
      bsel_q    <= bsel_d;
      rd_pend_q <= issue && !cur_we && (bsel_q != 2'd3);
      rd_idx_q  <= bsel_q;
      if (rd_pend_q) begin
        case (rd_idx_q)
          2'd0:    rdt_q[7:0]   <= i_sram_rdata;
          2'd1:    rdt_q[15:8]  <= i_sram_rdata;
          2'd2:    rdt_q[23:16] <= i_sram_rdata;
          default: rdt_q        <= rdt_q;
        endcase
      end
    end
  end

`ifdef SUBSERVIENT_ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= 1'b1;
    end else if ((state_q == S_IDLE) && any_stb) begin
      last_q <= pick;
    end
  end
`endif

endmodule

// File: tb/tb_subservient_sram_arb.sv
// Self-checking bench for subservient_sram_arb: transaction table with scoreboard plus reset/arbitration sequences.
module tb_subservient_sram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rf_waddr, rf_wdata, rf_raddr, rf_rdata;
  logic        rf_wen, rf_ren;
  logic [5:0]  m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat, m0_rdt, m1_rdt;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m1_we, m0_stb, m1_stb, m0_ack, m1_ack;
  logic [7:0]  sram_waddr, sram_wdata, sram_raddr;
  logic        sram_wen;
  logic [7:0]  sram_rdata;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic        preload;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  typedef struct {
    logic        m;
    logic        we;
    logic [5:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          stall_at;
    int          stall_len;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        m;
    logic        we;
    logic [31:0] rdt;
    int          lat;
  } sb_t;

  vec_t vecs [8];
  sb_t  sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  subservient_sram_arb #(.depth(256)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata), .i_rf_wen(rf_wen),
    .i_rf_raddr(rf_raddr), .i_rf_ren(rf_ren), .o_rf_rdata(rf_rdata),
    .i_wb_m0_adr(m0_adr), .i_wb_m0_dat(m0_dat), .i_wb_m0_sel(m0_sel),
    .i_wb_m0_we(m0_we), .i_wb_m0_stb(m0_stb), .o_wb_m0_rdt(m0_rdt), .o_wb_m0_ack(m0_ack),
    .i_wb_m1_adr(m1_adr), .i_wb_m1_dat(m1_dat), .i_wb_m1_sel(m1_sel),
    .i_wb_m1_we(m1_we), .i_wb_m1_stb(m1_stb), .o_wb_m1_rdt(m1_rdt), .o_wb_m1_ack(m1_ack),
    .o_sram_waddr(sram_waddr), .o_sram_wdata(sram_wdata), .o_sram_wen(sram_wen),
    .o_sram_raddr(sram_raddr), .i_sram_rdata(sram_rdata)
  );

  function automatic logic [7:0] init_byte(input logic [7:0] a);
    case (a)
      8'h14:   return 8'h11;
      8'h15:   return 8'h22;
      8'h16:   return 8'h33;
      8'h17:   return 8'h44;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  // Synchronous SRAM model: registered read, one cycle latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(8'(i));
    end else if (sram_wen) begin
      mem[sram_waddr] <= sram_wdata;
    end
    sram_rdata <= mem[sram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    sb_t e;
    int  start;
    bit  got;
    @(posedge clk); #1;
    if (!v.m) begin
      m0_adr = v.adr; m0_dat = v.dat; m0_sel = v.sel; m0_we = v.we; m0_stb = 1'b1;
    end else begin
      m1_adr = v.adr; m1_dat = v.dat; m1_sel = v.sel; m1_we = v.we; m1_stb = 1'b1;
    end
    e.m   = v.m;
    e.we  = v.we;
    e.lat = v.exp_lat;
    e.rdt = {ref_mem[{v.adr, 2'd3}], ref_mem[{v.adr, 2'd2}],
             ref_mem[{v.adr, 2'd1}], ref_mem[{v.adr, 2'd0}]};
    sbq.push_back(e);
    if (v.we) begin
      for (int b = 0; b < 4; b++)
        if (v.sel[b]) ref_mem[{v.adr, 2'(b)}] = 8'(v.dat >> (8 * b));
    end
    start = cyc;
    got   = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      rf_ren = (k >= v.stall_at) && (k < v.stall_at + v.stall_len);
      @(negedge clk);
      if (rf_ren) begin
        chk("stall_raddr", 32'(sram_raddr), 32'(rf_raddr));
        chk("stall_wen", 32'(sram_wen), 32'(rf_wen));
        chk("rf_rdata", 32'(rf_rdata), 32'(sram_rdata));
      end
      if (m0_ack || m1_ack) begin
        got = 1'b1;
        e = sbq.pop_front();
        chk("ack_who", {30'd0, m1_ack, m0_ack}, e.m ? 32'd2 : 32'd1);
        chk("latency", 32'(cyc - start), 32'(e.lat));
        if (!e.we) chk("rdt", e.m ? m1_rdt : m0_rdt, e.rdt);
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    m0_stb = 1'b0; m1_stb = 1'b0; rf_ren = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {30'd0, m1_ack, m0_ack}, 32'd0);
  endtask

  initial begin
    logic exp_g [3];
    bit   got;
    int   diffs;
    vec_t v;

`ifdef SUBSERVIENT_ARB_ROUND_ROBIN_EN
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
`else
    exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0;
`endif
    //        m     we    adr    dat           sel      at len lat
    vecs[0] = '{1'b0, 1'b0, 6'h05, 32'h0,        4'b1111, 0, 0, 5};
    vecs[1] = '{1'b1, 1'b1, 6'h02, 32'hAABBCCDD, 4'b0101, 0, 0, 5};
    vecs[2] = '{1'b0, 1'b0, 6'h05, 32'h0,        4'b1111, 2, 3, 8};
    vecs[3] = '{1'b1, 1'b0, 6'h02, 32'h0,        4'b1111, 0, 0, 5};
    vecs[4] = '{1'b0, 1'b1, 6'h10, 32'h01020304, 4'b1111, 1, 2, 7};
    vecs[5] = '{1'b0, 1'b0, 6'h10, 32'h0,        4'b1111, 0, 0, 5};
    vecs[6] = '{1'b1, 1'b1, 6'h11, 32'hFFFFFFFF, 4'b0000, 0, 0, 5};
    vecs[7] = '{1'b1, 1'b0, 6'h11, 32'h0,        4'b1111, 4, 1, 6};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(8'(i));
    rst_n = 1'b0; preload = 1'b1;
    rf_waddr = 8'h33; rf_wdata = 8'h00; rf_wen = 1'b0; rf_raddr = 8'hF0; rf_ren = 1'b0;
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_stb = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    preload = 1'b0;
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_wen", 32'(sram_wen), 32'd0);
    chk("rst_waddr", 32'(sram_waddr), 32'h33);
    chk("rst_raddr", 32'(sram_raddr), 32'hF0);
    chk("rst_rdt", {8'd0, m0_rdt[23:0]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // RF write passes straight through while idle
    @(posedge clk); #1;
    rf_wen = 1'b1; rf_wdata = 8'hC3;
    ref_mem[8'h33] = 8'hC3;
    @(negedge clk);
    chk("rf_wen_pass", 32'(sram_wen), 32'd1);
    chk("rf_wdata_pass", 32'(sram_wdata), 32'hC3);
    @(posedge clk); #1;
    rf_wen = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i]);
      if (i == 1) begin
        chk("sel_b0", 32'(mem[8]), 32'hDD);
        chk("sel_b1", 32'(mem[9]), 32'(init_byte(8'd9)));
        chk("sel_b2", 32'(mem[10]), 32'hBB);
        chk("sel_b3", 32'(mem[11]), 32'(init_byte(8'd11)));
      end
    end

    // Reset after byte 1 of an m0 write abandons the transfer
    @(posedge clk); #1;
    m0_adr = 6'h20; m0_dat = 32'hDEADBEEF; m0_sel = 4'b1111; m0_we = 1'b1; m0_stb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; m0_stb = 1'b0;
    ref_mem[8'h80] = 8'hEF; ref_mem[8'h81] = 8'hBE;
    @(negedge clk);
    chk("midrst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("midrst_wen", 32'(sram_wen), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (m0_ack || m1_ack) got = 1'b1;
    end
    chk("midrst_no_ack", 32'(got), 32'd0);
    chk("midrst_b0", 32'(mem[8'h80]), 32'hEF);
    chk("midrst_b1", 32'(mem[8'h81]), 32'hBE);
    chk("midrst_b2", 32'(mem[8'h82]), 32'(init_byte(8'h82)));
    chk("midrst_b3", 32'(mem[8'h83]), 32'(init_byte(8'h83)));

    // Simultaneous requests held continuously
    @(posedge clk); #1;
    m0_adr = 6'h05; m0_we = 1'b0; m0_stb = 1'b1;
    m1_adr = 6'h10; m1_we = 1'b0; m1_stb = 1'b1;
    for (int g = 0; g < 3; g++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (m0_ack || m1_ack) begin
          got = 1'b1;
          chk("arb_grant", {30'd0, m1_ack, m0_ack}, exp_g[g] ? 32'd2 : 32'd1);
          chk("arb_rdt", m1_ack ? m1_rdt : m0_rdt,
              m1_ack ? 32'h01020304 : 32'h44332211);
        end
      end
      if (!got) chk("arb_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    m0_stb = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        got = 1'b1;
        chk("arb_m1_served", {30'd0, m1_ack, m0_ack}, 32'd2);
      end
    end
    if (!got) chk("arb_m1_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    m1_stb = 1'b0;
    repeat (2) @(negedge clk);

    diffs = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 32'(diffs), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/subservient_sram_arb.md
SUBSERVIENT_SRAM_ARB -- requirements
Module: subservient_sram_arb

Interface
REQ-001 Parameter: depth, 256, SRAM size in bytes.
REQ-002 Parameter: aw, $clog2(depth), byte address width.
REQ-003 i_clk  in  1  sole clock; all state on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_rf_waddr / i_rf_wdata / i_rf_wen  in  aw / 8 / 1  register-file byte write port.
REQ-006 i_rf_raddr / i_rf_ren  in  aw / 1  register-file byte read port; o_rf_rdata  out  8  read data.
REQ-007 i_wb_m0_adr / i_wb_m1_adr  in  aw-2 each  word addresses, bits [aw-1:2].
REQ-008 i_wb_mN_dat  in  32;  i_wb_mN_sel  in  4;  i_wb_mN_we  in  1;  i_wb_mN_stb  in  1  (N = 0, 1).
REQ-009 o_wb_mN_rdt  out  32;  o_wb_mN_ack  out  1  (N = 0, 1).
REQ-010 o_sram_waddr / o_sram_wdata / o_sram_wen  out  aw / 8 / 1  shared SRAM write port.
REQ-011 o_sram_raddr  out  aw;  i_sram_rdata  in  8  (data valid one cycle after address).

Function
REQ-012 rf_act = i_rf_wen | i_rf_ren; RF SHALL always have priority on the SRAM.
REQ-013 FSM states IDLE, XFER, ACK; IDLE -> XFER when any stb high, grant latched at that edge, bsel cleared to 0.
REQ-014 XFER cycle with !rf_act SHALL issue byte bsel of granted master: addr {adr,bsel}, wdata dat[8*bsel+:8], wen = we & sel[bsel], then bsel increments.
REQ-015 XFER cycle with rf_act SHALL issue nothing for WB; bsel holds; SRAM ports carry RF signals unchanged.
REQ-016 Outside a WB issue cycle, o_sram_* SHALL equal i_rf_*; o_sram_wen = i_rf_wen.
REQ-017 o_rf_rdata SHALL equal i_sram_rdata combinationally at all times.
REQ-018 Byte issued for a WB read in cycle T SHALL be captured from i_sram_rdata at end of cycle T+1 into rdt byte bsel (bytes 0..2 registered).
REQ-019 Issuing byte 3 SHALL move XFER -> ACK; ACK lasts exactly one cycle, then -> IDLE.
REQ-020 In ACK, o_wb_mG_ack = 1 for granted master G only; o_wb_mG_rdt = {i_sram_rdata, rdt[23:0]}.
REQ-021 o_wb_mN_rdt SHALL be valid only in ACK for reads; write data bytes with sel=0 SHALL not be written.
REQ-022 Uncontended latency: stb seen in IDLE cycle N -> ack in cycle N+5; each RF-stalled XFER cycle adds one.
REQ-023 Masters SHALL hold stb and inputs until ack; stb drop mid-transfer SHALL NOT abort, ack still issued.
REQ-024 Non-granted master SHALL see ack = 0 and SHALL be served in a later IDLE.

Reset
REQ-025 On i_rst_n low (asynchronous): state IDLE, bsel 0, acks 0, rdt 0, last-grant = m1, no WB SRAM write issued.
REQ-026 Reset mid-transfer SHALL abandon it; partially written bytes remain; no ack follows.

Configuration
REQ-027 Macro SUBSERVIENT_ARB_ROUND_ROBIN_EN defined: simultaneous stb grants master not granted last; last-grant updates on every grant.
REQ-028 Macro undefined: fixed priority, m0 always wins simultaneous requests; last-grant register absent.

Verification
REQ-029 m0 read adr 0x05, SRAM bytes 0x14..0x17 = 11,22,33,44, no RF -> ack cycle N+5, rdt 0x44332211.
REQ-030 m1 write adr 0x02, dat 0xAABBCCDD, sel 0b0101 -> SRAM[8]=DD, SRAM[10]=BB, SRAM[9],[11] unchanged, ack N+5.
REQ-031 m0 read with i_rf_ren high for 3 cycles mid-XFER -> o_sram_raddr = i_rf_raddr those cycles, ack N+8, rdt correct.
REQ-032 Both stb from reset, ROUND_ROBIN_EN defined -> grants m0, m1, m0; undefined -> m0 repeatedly while m0 requests.
REQ-033 i_rst_n pulsed low after byte 1 of m0 write -> acks 0, state IDLE, SRAM bytes 0..1 written, 2..3 not.
